// File: rtl/vecunit_pkg.sv
// Shared types and result-word field positions for the vector FP result writeback path.
package vecunit_pkg;

    localparam int unsigned WB_DATA_W     = 32;
    localparam int unsigned RES_VALID_BIT = WB_DATA_W + 1;
    localparam int unsigned RES_MASK_BIT  = WB_DATA_W;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2,
        DONE    = 2'd3
    } wb_state_t;

endpackage

// File: rtl/wb_result_fifo.sv
// Synchronous result buffer between the FP lanes and the VRF write port.
// Show-ahead head output, no bypass from push to head.
module wb_result_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 34
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/vec_result_writeback.sv
// Collects per-element FP results, retires them in order to the VRF, pulses done.
// Build option WB_ZERO_FILL_EN: masked-off elements are written as zeros instead of skipped.
module vec_result_writeback #(
    parameter int unsigned DATA_W      = vecunit_pkg::WB_DATA_W,
    parameter int unsigned VREG_ADDR_W = 5,
    parameter int unsigned ELEM_IDX_W  = 6,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   start_i,
    input  logic [VREG_ADDR_W-1:0] vd_i,
    input  logic [ELEM_IDX_W:0]    vl_i,
    input  logic [DATA_W+1:0]      res_i,
    output logic                   res_ready_o,
    output logic                   vrf_req_o,
    output logic [VREG_ADDR_W-1:0] vrf_addr_o,
    output logic [ELEM_IDX_W-1:0]  vrf_idx_o,
    output logic [DATA_W-1:0]      vrf_wdata_o,
    input  logic                   vrf_gnt_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [ELEM_IDX_W:0]    masked_cnt_o
);

    import vecunit_pkg::*;

    localparam int unsigned CNT_W  = ELEM_IDX_W + 1;
    localparam int unsigned WORD_W = DATA_W + 2;
    localparam logic [CNT_W-1:0] MAX_VL = {1'b1, {ELEM_IDX_W{1'b0}}};

    wb_state_t              state_q, state_d;
    logic [VREG_ADDR_W-1:0] vd_q, vd_d;
    logic [CNT_W-1:0]       vl_q, vl_d;
    logic [CNT_W-1:0]       in_cnt_q, in_cnt_d;
    logic [CNT_W-1:0]       out_cnt_q, out_cnt_d;
    logic [CNT_W-1:0]       masked_cnt_q, masked_cnt_d;
    logic [CNT_W-1:0]       vl_clamped;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [WORD_W-1:0] fifo_head;
    logic              head_vld;
    logic              head_mask;
    logic [DATA_W-1:0] head_data;

    logic              res_ready;
    logic              req;
    logic [DATA_W-1:0] wdata;
    logic              done;

    wb_result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (WORD_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (fifo_push),
        .wdata_i (res_i),
        .pop_i   (fifo_pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (fifo_head)
    );

    assign vl_clamped = (vl_i > MAX_VL) ? MAX_VL : vl_i;
    assign head_vld   = fifo_head[RES_VALID_BIT];
    assign head_mask  = fifo_head[RES_MASK_BIT];
    assign head_data  = fifo_head[DATA_W-1:0];

    always_comb begin
        state_d      = state_q;
        vd_d         = vd_q;
        vl_d         = vl_q;
        in_cnt_d     = in_cnt_q;
        out_cnt_d    = out_cnt_q;
        masked_cnt_d = masked_cnt_q;
        res_ready    = 1'b0;
        req          = 1'b0;
        wdata        = '0;
        fifo_pop     = 1'b0;
        fifo_push    = 1'b0;
        done         = 1'b0;

        // Retirement reads only the registered head, so a fresh result never reaches the VRF combinationally.
        if ((state_q == COLLECT || state_q == DRAIN) && !fifo_empty && head_vld) begin
`ifdef WB_ZERO_FILL_EN
            req      = 1'b1;
            wdata    = head_mask ? head_data : '0;
            fifo_pop = vrf_gnt_i;
`else
            if (head_mask) begin
                req      = 1'b1;
                wdata    = head_data;
                fifo_pop = vrf_gnt_i;
            end else begin
                fifo_pop = 1'b1;
            end
`endif
        end

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (vl_i == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d      = COLLECT;
                        vd_d         = vd_i;
                        vl_d         = vl_clamped;
                        in_cnt_d     = '0;
                        out_cnt_d    = '0;
                        masked_cnt_d = '0;
                    end
                end
            end
            COLLECT: begin
                res_ready = !fifo_full && (in_cnt_q < vl_q);
                if (in_cnt_q == vl_q) state_d = DRAIN;
            end
            DRAIN: begin
                if (fifo_empty && out_cnt_q == vl_q) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        fifo_push = res_i[RES_VALID_BIT] && res_ready;
        if (fifo_push) in_cnt_d = in_cnt_d + 1'b1;
        if (fifo_pop) begin
            out_cnt_d = out_cnt_d + 1'b1;
            if (!head_mask) masked_cnt_d = masked_cnt_d + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            vd_q         <= '0;
            vl_q         <= '0;
            in_cnt_q     <= '0;
            out_cnt_q    <= '0;
            masked_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            vd_q         <= vd_d;
            vl_q         <= vl_d;
            in_cnt_q     <= in_cnt_d;
            out_cnt_q    <= out_cnt_d;
            masked_cnt_q <= masked_cnt_d;
        end
    end

    assign res_ready_o  = res_ready;
    assign vrf_req_o    = req;
    assign vrf_addr_o   = vd_q;
    assign vrf_idx_o    = out_cnt_q[ELEM_IDX_W-1:0];
    assign vrf_wdata_o  = wdata;
    assign busy_o       = (state_q != IDLE);
    assign done_o       = done;
    assign masked_cnt_o = masked_cnt_q;

endmodule

// File: tb/tb_vec_result_writeback.sv
// Randomized bench for vec_result_writeback: expected VRF writes are derived from the element list.
// Honours WB_ZERO_FILL_EN when the bundle is built with it.
module tb_vec_result_writeback;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        start_i;
    logic [4:0]  vd_i;
    logic [6:0]  vl_i;
    logic [33:0] res_i;
    logic        res_ready_o;
    logic        vrf_req_o;
    logic [4:0]  vrf_addr_o;
    logic [5:0]  vrf_idx_o;
    logic [31:0] vrf_wdata_o;
    logic        vrf_gnt_i;
    logic        busy_o;
    logic        done_o;
    logic [6:0]  masked_cnt_o;

    int compared   = 0;
    int mismatched = 0;

    bit [31:0]   elemData[$];
    bit          elemMask[$];
    logic [42:0] gotQ[$];
    logic        stallPrev = 1'b0;
    logic [42:0] stallWord = '0;

    always #5 clk = ~clk;

    vec_result_writeback dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .start_i      (start_i),
        .vd_i         (vd_i),
        .vl_i         (vl_i),
        .res_i        (res_i),
        .res_ready_o  (res_ready_o),
        .vrf_req_o    (vrf_req_o),
        .vrf_addr_o   (vrf_addr_o),
        .vrf_idx_o    (vrf_idx_o),
        .vrf_wdata_o  (vrf_wdata_o),
        .vrf_gnt_i    (vrf_gnt_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .masked_cnt_o (masked_cnt_o)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Records every completed VRF write and checks that a stalled request holds its payload.
    always @(negedge clk) begin
        if (stallPrev) begin
            checkOutput("stall_req", vrf_req_o, 1);
            checkOutput("stall_payload", {vrf_addr_o, vrf_idx_o, vrf_wdata_o}, stallWord);
        end
        stallPrev = rst_ni && vrf_req_o && !vrf_gnt_i;
        stallWord = {vrf_addr_o, vrf_idx_o, vrf_wdata_o};
        if (rst_ni && vrf_req_o && vrf_gnt_i)
            gotQ.push_back({vrf_addr_o, vrf_idx_o, vrf_wdata_o});
    end

    task automatic sampleWait();
        @(negedge clk);
        #1;
    endtask

    task automatic fillElems(input int n, input bit allUnmasked);
        elemData.delete();
        elemMask.delete();
        for (int i = 0; i < n; i++) begin
            elemData.push_back($urandom);
            elemMask.push_back(allUnmasked ? 1'b1 : ($urandom_range(0, 3) != 0));
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput(tag, {res_ready_o, vrf_req_o, vrf_addr_o, vrf_idx_o, vrf_wdata_o,
                          busy_o, done_o, masked_cnt_o}, 64'd0);
    endtask

    // gntMode: 0 = grant always high, 1 = random grant, 2 = grant low for the first 10 cycles.
    task automatic applyStimulus(input logic [4:0] vd, input logic [6:0] vlReq, input int gntMode,
                                 input bit noisy, input string name);
        int          n;
        int          expMasked;
        int          k;
        int          cyc;
        bit          doneSeen;
        logic [42:0] expQ[$];

        n         = (vlReq > 7'd64) ? 64 : int'(vlReq);
        expMasked = 0;
        k         = 0;
        cyc       = 0;
        doneSeen  = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (elemMask[i]) begin
                expQ.push_back({vd, 6'(i), elemData[i]});
            end else begin
                expMasked++;
`ifdef WB_ZERO_FILL_EN
                expQ.push_back({vd, 6'(i), 32'h0});
`endif
            end
        end
        gotQ.delete();

        @(posedge clk);
        #1;
        start_i = 1'b1;
        vd_i    = vd;
        vl_i    = vlReq;
        res_i   = '0;

        while (!doneSeen && cyc < 3000) begin
            @(posedge clk);
            #1;
            start_i = noisy && ($urandom_range(0, 5) == 0);
            vl_i    = 7'($urandom);
            vd_i    = 5'($urandom);
            case (gntMode)
                0:       vrf_gnt_i = 1'b1;
                1:       vrf_gnt_i = ($urandom_range(0, 2) != 0);
                default: vrf_gnt_i = (cyc >= 10);
            endcase
            if (k < n && (!noisy || $urandom_range(0, 3) != 0))
                res_i = {1'b1, elemMask[k], elemData[k]};
            else
                res_i = {1'b0, 1'($urandom), $urandom};
            sampleWait();
            if (cyc == 0) checkOutput({name, "_busy"}, busy_o, 1);
            if (gntMode == 2 && cyc == 9) begin
                checkOutput({name, "_accepted_when_full"}, k, 4);
                checkOutput({name, "_ready_when_full"}, res_ready_o, 0);
                checkOutput({name, "_waiting_req"}, vrf_req_o, 1);
                checkOutput({name, "_waiting_idx"}, vrf_idx_o, 0);
                checkOutput({name, "_waiting_data"}, vrf_wdata_o, elemData[0]);
            end
            if (res_i[33] && res_ready_o) k++;
            if (done_o) doneSeen = 1'b1;
            cyc++;
        end
        start_i = 1'b0;
        res_i   = '0;

        checkOutput({name, "_done_seen"}, doneSeen, 1);
        checkOutput({name, "_accepted"}, k, n);
        checkOutput({name, "_masked_cnt"}, masked_cnt_o, expMasked);
        sampleWait();
        checkOutput({name, "_done_one_cycle"}, done_o, 0);
        checkOutput({name, "_idle_after"}, busy_o, 0);
        checkOutput({name, "_write_count"}, gotQ.size(), expQ.size());
        for (int i = 0; i < expQ.size() && i < gotQ.size(); i++)
            checkOutput($sformatf("%s_write%0d", name, i), gotQ[i], expQ[i]);
    endtask

    initial begin
        int k;
        int cyc;

        rst_ni    = 1'b0;
        start_i   = 1'b0;
        vd_i      = '0;
        vl_i      = '0;
        res_i     = '0;
        vrf_gnt_i = 1'b0;
        repeat (2) @(posedge clk);
        sampleWait();
        checkIdleOutputs("reset_outputs");
        @(posedge clk);
        #1;
        rst_ni = 1'b1;

        elemData = '{32'd1, 32'd2, 32'd3, 32'd4};
        elemMask = '{1'b1, 1'b1, 1'b1, 1'b1};
        applyStimulus(5'd3, 7'd4, 0, 1'b0, "basic");

        elemData = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003};
        elemMask = '{1'b1, 1'b0, 1'b1};
        applyStimulus(5'd5, 7'd3, 0, 1'b0, "masked");

        fillElems(8, 1'b1);
        applyStimulus(5'd9, 7'd8, 2, 1'b0, "backpressure");

        // Zero-length instruction goes straight to DONE.
        gotQ.delete();
        @(posedge clk);
        #1;
        start_i = 1'b1;
        vl_i    = 7'd0;
        vd_i    = 5'd4;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        sampleWait();
        checkOutput("vl0_done", done_o, 1);
        checkOutput("vl0_busy", busy_o, 1);
        checkOutput("vl0_req", vrf_req_o, 0);
        sampleWait();
        checkOutput("vl0_done_after", done_o, 0);
        checkOutput("vl0_busy_after", busy_o, 0);
        checkOutput("vl0_no_writes", gotQ.size(), 0);

        // Abort an instruction after two retirements, then start fresh.
        fillElems(5, 1'b1);
        gotQ.delete();
        @(posedge clk);
        #1;
        start_i   = 1'b1;
        vd_i      = 5'd7;
        vl_i      = 7'd5;
        vrf_gnt_i = 1'b1;
        k   = 0;
        cyc = 0;
        while (gotQ.size() < 2 && cyc < 100) begin
            @(posedge clk);
            #1;
            start_i = 1'b0;
            res_i   = (k < 5) ? {1'b1, 1'b1, elemData[k]} : 34'd0;
            sampleWait();
            if (res_i[33] && res_ready_o) k++;
            cyc++;
        end
        checkOutput("abort_progress", gotQ.size(), 2);
        checkOutput("abort_in_collect", res_ready_o | (k < 5), 1);
        @(posedge clk);
        #1;
        rst_ni    = 1'b0;
        res_i     = '0;
        vrf_gnt_i = 1'b0;
        @(posedge clk);
        sampleWait();
        checkIdleOutputs("abort_outputs");
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        fillElems(2, 1'b1);
        applyStimulus(5'd2, 7'd2, 0, 1'b0, "post_reset");

        for (int r = 0; r < 8; r++) begin
            int vl;
            vl = $urandom_range(1, 20);
            fillElems(vl, 1'b0);
            applyStimulus(5'($urandom), 7'(vl), 1, 1'b1, $sformatf("rand%0d", r));
        end

        fillElems(64, 1'b0);
        applyStimulus(5'd17, 7'd100, 1, 1'b0, "clamp");

        fillElems(64, 1'b0);
        applyStimulus(5'd31, 7'd64, 0, 1'b1, "maxvl");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
